// File: rtl/uart_transmitter_parity.sv
// UART transmitter: start bit, 8 data bits LSB first, parity bit, 1 or 2 stop bits.
// A one-entry holding buffer with a valid/ready handshake lets frames run back to back.
module uart_transmitter_parity #(
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CNT_W = 17;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic             ODD       = 1'(PARITY_ODD);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state, state_n;
    logic [7:0]       buf_data, buf_data_n;
    logic             buf_full, buf_full_n;
    logic [7:0]       shift, shift_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [CNT_W-1:0] baud_cnt, baud_n;
    logic             parity, parity_n;
    logic             tx_n;
    logic             done_n;
    logic             load;
    logic             bit_end;
    logic             stop_end;

    assign ready = ~buf_full;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            buf_data <= '0;
            buf_full <= 1'b0;
            shift    <= '0;
            bit_idx  <= '0;
            baud_cnt <= '0;
            parity   <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            buf_data <= buf_data_n;
            buf_full <= buf_full_n;
            shift    <= shift_n;
            bit_idx  <= bit_idx_n;
            baud_cnt <= baud_n;
            parity   <= parity_n;
            tx       <= tx_n;
            busy     <= (state_n != IDLE);
            done     <= done_n;
        end
    end

    // Next-state, handshake and line-level logic
    always_comb begin
        state_n    = state;
        buf_data_n = buf_data;
        buf_full_n = buf_full;
        shift_n    = shift;
        bit_idx_n  = bit_idx;
        baud_n     = baud_cnt;
        parity_n   = parity;
        tx_n       = tx;
        done_n     = 1'b0;
        load       = 1'b0;
        bit_end    = (baud_cnt == BIT_LAST);
        stop_end   = (baud_cnt == STOP_LAST);

        if (valid && !buf_full) begin
            buf_data_n = din;
            buf_full_n = 1'b1;
        end

        case (state)
            IDLE: begin
                tx_n = 1'b1;
                load = buf_full;
            end
            START: begin
                if (bit_end) begin
                    baud_n  = '0;
                    state_n = DATA;
                    tx_n    = shift[0];
                end else begin
                    baud_n = CNT_W'(baud_cnt + 1'b1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n   = PARITY;
                        tx_n      = parity;
                        bit_idx_n = '0;
                    end else begin
                        shift_n   = {1'b0, shift[7:1]};
                        tx_n      = shift[1];
                        bit_idx_n = 3'(bit_idx + 1'b1);
                    end
                end else begin
                    baud_n = CNT_W'(baud_cnt + 1'b1);
                end
            end
            PARITY: begin
                if (bit_end) begin
                    baud_n  = '0;
                    state_n = STOP;
                    tx_n    = 1'b1;
                end else begin
                    baud_n = CNT_W'(baud_cnt + 1'b1);
                end
            end
            STOP: begin
                if (stop_end) begin
                    baud_n  = '0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                    tx_n    = 1'b1;
                    load    = buf_full;
                end else begin
                    baud_n = CNT_W'(baud_cnt + 1'b1);
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase

        // Buffer drains into the shift register; parity latched from the same byte
        if (load) begin
            state_n    = START;
            tx_n       = 1'b0;
            shift_n    = buf_data;
            buf_full_n = 1'b0;
            parity_n   = (^buf_data) ^ ODD;
            baud_n     = '0;
            bit_idx_n  = '0;
        end
    end

endmodule

// File: tb/tb_uart_transmitter_parity.sv
// Directed bench for uart_transmitter_parity: three parameterisations plus a
// one-bit-per-clock parity receiver model watching the default instance.
module tb_uart_transmitter_parity;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din [3];
    logic [2:0] valid = '0;
    logic [2:0] ready;
    logic [2:0] tx_o;
    logic [2:0] busy;
    logic [2:0] done_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_transmitter_parity u0 (
        .clk(clk), .rst(rst), .din(din[0]), .valid(valid[0]),
        .ready(ready[0]), .tx(tx_o[0]), .busy(busy[0]), .done(done_o[0])
    );

    uart_transmitter_parity #(.CLKS_PER_BIT(1), .PARITY_ODD(1), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .din(din[1]), .valid(valid[1]),
        .ready(ready[1]), .tx(tx_o[1]), .busy(busy[1]), .done(done_o[1])
    );

    uart_transmitter_parity #(.CLKS_PER_BIT(4), .PARITY_ODD(0), .STOP_BITS(2)) u2 (
        .clk(clk), .rst(rst), .din(din[2]), .valid(valid[2]),
        .ready(ready[2]), .tx(tx_o[2]), .busy(busy[2]), .done(done_o[2])
    );

    // Receiver model on u0's line: one bit per clock, even parity, one stop bit
    logic [7:0] rx_q [$];
    logic [7:0] rx_sh;
    logic       rx_par;
    int         rx_cnt  = 0;
    int         rx_perr = 0;
    int         rx_ferr = 0;
    int         done_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            rx_cnt = 0;
        end else begin
            if (done_o[0]) done_cnt++;
            if (rx_cnt == 0) begin
                if (tx_o[0] == 1'b0) rx_cnt = 1;
            end else if (rx_cnt <= 8) begin
                rx_sh[rx_cnt-1] = tx_o[0];
                rx_cnt++;
            end else if (rx_cnt == 9) begin
                rx_par = tx_o[0];
                if (rx_par !== ^rx_sh) rx_perr++;
                rx_cnt++;
            end else begin
                if (tx_o[0] !== 1'b1) rx_ferr++;
                rx_q.push_back(rx_sh);
                rx_cnt = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input int s);
        for (int i = 0; i < 200 && ready[s] !== 1'b1; i++) step();
        chk($sformatf("ready_wait s%0d", s), 32'(ready[s]), 32'd1);
    endtask

    // Offer a byte; returns just after the accepting edge with valid dropped
    task automatic send(input int s, input logic [7:0] b);
        wait_ready(s);
        din[s]   = b;
        valid[s] = 1'b1;
        step();
        valid[s] = 1'b0;
    endtask

    // Called just after the edge that put the start bit on tx
    task automatic frame(input int s, input logic [7:0] b, input logic par,
                         input int cpb, input int stops, input logic [8:0] after);
        int   n;
        int   bi;
        logic e;
        n = (10 + stops) * cpb;
        for (int k = 0; k < n; k++) begin
            bi = k / cpb;
            if (bi == 0)      e = 1'b0;
            else if (bi <= 8) e = b[bi-1];
            else if (bi == 9) e = par;
            else              e = 1'b1;
            chk($sformatf("tx s%0d b%02h k%0d", s, b, k), 32'(tx_o[s]), 32'(e));
            chk($sformatf("busy s%0d k%0d", s, k), 32'(busy[s]), 32'd1);
            if (k > 0) chk($sformatf("done s%0d k%0d", s, k), 32'(done_o[s]), 32'd0);
            step();
            if (k == 0) begin
                valid[s] = after[8];
                din[s]   = after[7:0];
            end
        end
    endtask

    task automatic end_idle(input int s);
        chk($sformatf("end done s%0d", s), 32'(done_o[s]), 32'd1);
        chk($sformatf("end busy s%0d", s), 32'(busy[s]), 32'd0);
        chk($sformatf("end tx s%0d", s), 32'(tx_o[s]), 32'd1);
        step();
        chk($sformatf("done drop s%0d", s), 32'(done_o[s]), 32'd0);
    endtask

    logic [7:0] lb [4];
    int base_q;
    int base_d;

    initial begin
        for (int i = 0; i < 3; i++) din[i] = '0;
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst tx s%0d", i), 32'(tx_o[i]), 32'd1);
            chk($sformatf("rst busy s%0d", i), 32'(busy[i]), 32'd0);
            chk($sformatf("rst done s%0d", i), 32'(done_o[i]), 32'd0);
            chk($sformatf("rst ready s%0d", i), 32'(ready[i]), 32'd1);
        end
        rst = 1'b0;
        step();

        // 0xA5 while idle: one-cycle ready low, start after the next edge
        send(0, 8'hA5);
        chk("a5 ready low", 32'(ready[0]), 32'd0);
        chk("a5 tx idle", 32'(tx_o[0]), 32'd1);
        chk("a5 busy pre", 32'(busy[0]), 32'd0);
        step();
        chk("a5 ready back", 32'(ready[0]), 32'd1);
        frame(0, 8'hA5, 1'b0, 1, 1, 9'h000);
        end_idle(0);

        // 0x07 odd parity -> 0, even parity -> 1
        send(1, 8'h07);
        step();
        frame(1, 8'h07, 1'b0, 1, 1, 9'h000);
        end_idle(1);
        send(0, 8'h07);
        step();
        frame(0, 8'h07, 1'b1, 1, 1, 9'h000);
        end_idle(0);

        // Back to back 0x00 then 0xFF with no idle gap
        send(0, 8'h00);
        step();
        din[0]   = 8'hFF;
        valid[0] = 1'b1;
        frame(0, 8'h00, 1'b0, 1, 1, 9'h000);
        chk("b2b start tx", 32'(tx_o[0]), 32'd0);
        chk("b2b done", 32'(done_o[0]), 32'd1);
        chk("b2b busy", 32'(busy[0]), 32'd1);
        frame(0, 8'hFF, 1'b0, 1, 1, 9'h000);
        end_idle(0);

        // 4 clocks/bit, 2 stop bits; 0xEE held while full must be ignored
        send(2, 8'h3C);
        step();
        din[2]   = 8'h55;
        valid[2] = 1'b1;
        frame(2, 8'h3C, 1'b0, 4, 2, 9'h1EE);
        valid[2] = 1'b0;
        chk("slow b2b tx", 32'(tx_o[2]), 32'd0);
        chk("slow b2b done", 32'(done_o[2]), 32'd1);
        chk("slow b2b busy", 32'(busy[2]), 32'd1);
        frame(2, 8'h55, 1'b0, 4, 2, 9'h000);
        end_idle(2);
        for (int i = 0; i < 6; i++) step();
        chk("slow no extra busy", 32'(busy[2]), 32'd0);
        chk("slow no extra tx", 32'(tx_o[2]), 32'd1);

        // Reset during data bit 3 with 0x99 buffered
        send(0, 8'hC3);
        step();
        din[0]   = 8'h99;
        valid[0] = 1'b1;
        step();
        valid[0] = 1'b0;
        step();
        step();
        step();
        chk("mid bit3 tx", 32'(tx_o[0]), 32'd0);
        chk("mid buffered", 32'(ready[0]), 32'd0);
        base_d = done_cnt;
        rst = 1'b1;
        #1;
        chk("async tx", 32'(tx_o[0]), 32'd1);
        chk("async busy", 32'(busy[0]), 32'd0);
        chk("async ready", 32'(ready[0]), 32'd1);
        step();
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            chk($sformatf("post rst tx c%0d", i), 32'(tx_o[0]), 32'd1);
            chk($sformatf("post rst busy c%0d", i), 32'(busy[0]), 32'd0);
        end
        chk("post rst no done", 32'(done_cnt - base_d), 32'd0);
        send(0, 8'h81);
        step();
        frame(0, 8'h81, 1'b0, 1, 1, 9'h000);
        end_idle(0);

        // Loopback into the receiver model
        lb[0] = 8'h00; lb[1] = 8'h5A; lb[2] = 8'hFF; lb[3] = 8'h81;
        base_q = rx_q.size();
        base_d = done_cnt;
        for (int i = 0; i < 4; i++) send(0, lb[i]);
        for (int i = 0; i < 200 && (busy[0] === 1'b1 || ready[0] !== 1'b1); i++) step();
        chk("loop idle", 32'(busy[0]), 32'd0);
        step();
        step();
        chk("loop count", 32'(rx_q.size() - base_q), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (base_q + i < rx_q.size())
                chk($sformatf("loop byte %0d", i), 32'(rx_q[base_q+i]), 32'(lb[i]));
        end
        chk("loop done count", 32'(done_cnt - base_d), 32'd4);
        chk("loop parity errs", 32'(rx_perr), 32'd0);
        chk("loop stop errs", 32'(rx_ferr), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
